// File: rtl/game_pkg.sv
// Shared game-state definitions for the VGA game.
// The menu controller, the renderer and the play logic all use this package.
//   STATE_W      : width of the game-state bus
//   game_state_e : fixed state encoding MENU/PLAY/PAUSE/OVER
//   clog2_min1   : ceil(log2(v)) with a floor of 1 bit, used for counter widths
package game_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        MENU  = 2'b00,
        PLAY  = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } game_state_e;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// One-bit rising-edge detector for an already synchronised button level.
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   btn  : button level
//   evt  : high in the cycle where btn is high and was low on the previous edge
// prev resets to 1. A button held through reset therefore produces no event
// until it has been released and pressed again.
module btn_edge (
    input  logic clk,
    input  logic rstn,
    input  logic btn,
    output logic evt
);

    logic r_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= btn;
        end
    end

    assign evt = btn & ~r_prev;

endmodule

// File: rtl/menu_ctrl.sv
// Top-level game-state controller: menu cursor, game start, pause and
// game-over sequencing.
//   clk, rstn        : system clock, asynchronous active-low reset
//   btn_up/btn_down  : move the menu cursor (levels)
//   btn_sel          : select / confirm / quit (level)
//   btn_pause        : pause toggle (level)
//   game_over        : from play logic; only looked at in PLAY
//   state            : current game state (game_pkg encoding)
//   sel_idx          : menu cursor position
//   mode             : menu entry latched at game start
//   start_pulse      : one-cycle pulse on every MENU->PLAY transition
// All outputs come straight from registers.
//
// state | meaning
// MENU  | cursor moves with up/down, sel starts a game
// PLAY  | game running; game_over ends it, pause suspends it
// PAUSE | suspended; pause resumes, sel quits to the menu
// OVER  | game-over screen; sel returns to the menu once the guard expires
module menu_ctrl
    import game_pkg::*;
#(
    parameter int NUM_ITEMS = 4,
    parameter int IDX_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
    parameter int GUARD_CYC = 50_000_000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_sel,
    input  logic               btn_pause,
    input  logic               game_over,
    output logic [STATE_W-1:0] state,
    output logic [IDX_W-1:0]   sel_idx,
    output logic [IDX_W-1:0]   mode,
    output logic               start_pulse
);

    localparam int               GW         = clog2_min1(GUARD_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ITEMS - 1);
    localparam logic [GW-1:0]    GUARD_LOAD = GW'(GUARD_CYC);

    logic w_evt_up;
    logic w_evt_down;
    logic w_evt_sel;
    logic w_evt_pause;

    btn_edge u_edge_up    (.clk(clk), .rstn(rstn), .btn(btn_up),    .evt(w_evt_up));
    btn_edge u_edge_down  (.clk(clk), .rstn(rstn), .btn(btn_down),  .evt(w_evt_down));
    btn_edge u_edge_sel   (.clk(clk), .rstn(rstn), .btn(btn_sel),   .evt(w_evt_sel));
    btn_edge u_edge_pause (.clk(clk), .rstn(rstn), .btn(btn_pause), .evt(w_evt_pause));

    game_state_e      r_state;
    logic [IDX_W-1:0] r_sel_idx;
    logic [IDX_W-1:0] r_mode;
    logic             r_start;
    logic [GW-1:0]    r_guard;

    game_state_e      w_state_nxt;
    logic [IDX_W-1:0] w_sel_nxt;
    logic [IDX_W-1:0] w_mode_nxt;
    logic             w_start_nxt;
    logic [GW-1:0]    w_guard_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= MENU;
            r_sel_idx <= '0;
            r_mode    <= '0;
            r_start   <= 1'b0;
            r_guard   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel_idx <= w_sel_nxt;
            r_mode    <= w_mode_nxt;
            r_start   <= w_start_nxt;
            r_guard   <= w_guard_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel_idx;
        w_mode_nxt  = r_mode;
        w_start_nxt = 1'b0;
        w_guard_nxt = r_guard;

        case (r_state)
            MENU: begin
                // sel wins over a same-cycle cursor move, so the un-moved
                // cursor is what gets latched as the mode.
                if (w_evt_sel) begin
                    w_state_nxt = PLAY;
                    w_mode_nxt  = r_sel_idx;
                    w_start_nxt = 1'b1;
                end else if (w_evt_up && !w_evt_down) begin
                    w_sel_nxt = (r_sel_idx == '0) ? LAST_IDX : r_sel_idx - IDX_W'(1);
                end else if (w_evt_down && !w_evt_up) begin
                    w_sel_nxt = (r_sel_idx == LAST_IDX) ? '0 : r_sel_idx + IDX_W'(1);
                end
            end
            PLAY: begin
                if (game_over) begin
                    w_state_nxt = OVER;
                    w_guard_nxt = GUARD_LOAD;
                end else if (w_evt_pause) begin
                    w_state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (w_evt_pause) begin
                    w_state_nxt = PLAY;
                end else if (w_evt_sel) begin
                    w_state_nxt = MENU;
                end
            end
            OVER: begin
                // The counter is sampled before it decrements, so a sel is
                // first accepted GUARD_CYC+1 edges after entering OVER.
                if (r_guard != '0) begin
                    w_guard_nxt = r_guard - GW'(1);
                end else if (w_evt_sel) begin
                    w_state_nxt = MENU;
                end
            end
            default: begin
                w_state_nxt = MENU;
            end
        endcase
    end

    assign state       = r_state;
    assign sel_idx     = r_sel_idx;
    assign mode        = r_mode;
    assign start_pulse = r_start;

endmodule

// File: tb/tb_menu_ctrl.sv
// Bench for menu_ctrl. Three instances share the same inputs:
//   u0: NUM_ITEMS=4, GUARD_CYC=10
//   u1: NUM_ITEMS=3, GUARD_CYC=2
//   u2: NUM_ITEMS=1, GUARD_CYC=0
// A behavioural model per instance predicts every output after every edge.
module tb_menu_ctrl;

    logic clk = 1'b0;
    logic rstn;
    logic btn_up, btn_down, btn_sel, btn_pause, game_over;

    logic [1:0] st0, st1, st2;
    logic [1:0] sel0, sel1, mode0, mode1;
    logic [0:0] sel2, mode2;
    logic       sp0, sp1, sp2;

    always #5 clk = ~clk;

    menu_ctrl #(.NUM_ITEMS(4), .GUARD_CYC(10)) u0 (
        .clk(clk), .rstn(rstn), .btn_up(btn_up), .btn_down(btn_down),
        .btn_sel(btn_sel), .btn_pause(btn_pause), .game_over(game_over),
        .state(st0), .sel_idx(sel0), .mode(mode0), .start_pulse(sp0));

    menu_ctrl #(.NUM_ITEMS(3), .GUARD_CYC(2)) u1 (
        .clk(clk), .rstn(rstn), .btn_up(btn_up), .btn_down(btn_down),
        .btn_sel(btn_sel), .btn_pause(btn_pause), .game_over(game_over),
        .state(st1), .sel_idx(sel1), .mode(mode1), .start_pulse(sp1));

    menu_ctrl #(.NUM_ITEMS(1), .GUARD_CYC(0)) u2 (
        .clk(clk), .rstn(rstn), .btn_up(btn_up), .btn_down(btn_down),
        .btn_sel(btn_sel), .btn_pause(btn_pause), .game_over(game_over),
        .state(st2), .sel_idx(sel2), .mode(mode2), .start_pulse(sp2));

    localparam int S_MENU = 0, S_PLAY = 1, S_PAUSE = 2, S_OVER = 3;
    localparam int NI [3] = '{4, 3, 1};
    localparam int GC [3] = '{10, 2, 0};

    int n_cmp = 0;
    int n_bad = 0;

    int m_state [3];
    int m_sel   [3];
    int m_mode  [3];
    int m_start [3];
    int m_since [3];
    int m_prev  [4];

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int obs(input int k, input int f);
        logic [3:0] v;
        v = '0;
        case (k)
            0: case (f) 0: v = {2'b0, st0}; 1: v = {2'b0, sel0}; 2: v = {2'b0, mode0}; default: v = {3'b0, sp0}; endcase
            1: case (f) 0: v = {2'b0, st1}; 1: v = {2'b0, sel1}; 2: v = {2'b0, mode1}; default: v = {3'b0, sp1}; endcase
            default: case (f) 0: v = {2'b0, st2}; 1: v = {3'b0, sel2}; 2: v = {3'b0, mode2}; default: v = {3'b0, sp2}; endcase
        endcase
        return int'(v);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_state[k] = S_MENU;
            m_sel[k]   = 0;
            m_mode[k]  = 0;
            m_start[k] = 0;
            m_since[k] = 0;
        end
        for (int b = 0; b < 4; b++) m_prev[b] = 1;
    endfunction

    // Applies one rising edge's worth of behaviour using the current inputs.
    function automatic void model_edge();
        int lv [4];
        bit eu, ed, es, ep;
        lv[0] = int'(btn_up);  lv[1] = int'(btn_down);
        lv[2] = int'(btn_sel); lv[3] = int'(btn_pause);
        eu = (lv[0] == 1) && (m_prev[0] == 0);
        ed = (lv[1] == 1) && (m_prev[1] == 0);
        es = (lv[2] == 1) && (m_prev[2] == 0);
        ep = (lv[3] == 1) && (m_prev[3] == 0);
        for (int b = 0; b < 4; b++) m_prev[b] = lv[b];
        for (int k = 0; k < 3; k++) begin
            m_start[k] = 0;
            case (m_state[k])
                S_MENU: begin
                    if (es) begin
                        m_state[k] = S_PLAY;
                        m_mode[k]  = m_sel[k];
                        m_start[k] = 1;
                    end else if (eu && !ed) begin
                        m_sel[k] = (m_sel[k] + NI[k] - 1) % NI[k];
                    end else if (ed && !eu) begin
                        m_sel[k] = (m_sel[k] + 1) % NI[k];
                    end
                end
                S_PLAY: begin
                    if (game_over) begin
                        m_state[k] = S_OVER;
                        m_since[k] = 0;
                    end else if (ep) begin
                        m_state[k] = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (ep) m_state[k] = S_PLAY;
                    else if (es) m_state[k] = S_MENU;
                end
                default: begin
                    m_since[k]++;
                    if (es && m_since[k] >= GC[k] + 1) m_state[k] = S_MENU;
                end
            endcase
        end
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s.u%0d.state", tag, k), obs(k, 0), m_state[k]);
            check($sformatf("%s.u%0d.sel_idx", tag, k), obs(k, 1), m_sel[k]);
            check($sformatf("%s.u%0d.mode", tag, k), obs(k, 2), m_mode[k]);
            check($sformatf("%s.u%0d.start", tag, k), obs(k, 3), m_start[k]);
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // mask bits: 0 up, 1 down, 2 sel, 3 pause
    task automatic press(input logic [3:0] mask, input string tag);
        {btn_pause, btn_sel, btn_down, btn_up} = mask;
        step(tag);
        {btn_pause, btn_sel, btn_down, btn_up} = 4'b0;
        step({tag, "_rel"});
    endtask

    // Called just after a sampling point; drops reset between edges.
    task automatic async_reset(input string tag);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_pause = 1'b0; game_over = 1'b0;
        btn_sel = 1'b1;
        model_reset();
        #12;
        check_all("reset");
        rstn = 1'b1;

        for (int i = 0; i < 3; i++) step("held_sel");
        check("held_sel_menu", obs(0, 0), S_MENU);
        btn_sel = 1'b0;
        step("sel_release");
        btn_sel = 1'b1;
        step("sel_press");
        check("start_state", obs(0, 0), S_PLAY);
        check("start_pulse_hi", obs(0, 3), 1);
        step("sel_hold");
        check("start_pulse_lo", obs(0, 3), 0);
        btn_sel = 1'b0;
        step("sel_rel2");

        press(4'b1000, "to_pause");
        press(4'b0100, "to_menu");
        check("back_menu", obs(0, 0), S_MENU);

        press(4'b0001, "up_wrap");
        check("wrap_up", obs(0, 1), 3);
        press(4'b0010, "down1");
        press(4'b0010, "down2");
        check("wrap_down", obs(0, 1), 1);
        press(4'b0011, "up_down");
        check("up_down_hold", obs(0, 1), 1);
        check("n1_sel", obs(2, 1), 0);
        press(4'b0100, "start_mode");
        check("mode_latch", obs(0, 2), 1);
        check("n1_mode", obs(2, 2), 0);
        check("n1_play", obs(2, 0), S_PLAY);

        game_over = 1'b1; btn_pause = 1'b1;
        step("over_vs_pause");
        game_over = 1'b0; btn_pause = 1'b0;
        check("over_wins", obs(0, 0), S_OVER);
        for (int i = 1; i <= 4; i++) step("guard_idle");
        btn_sel = 1'b1;
        step("guard_sel5");
        check("guard_block", obs(0, 0), S_OVER);
        btn_sel = 1'b0;
        for (int i = 6; i <= 11; i++) step("guard_idle2");
        btn_sel = 1'b1;
        step("guard_sel12");
        check("guard_accept", obs(0, 0), S_MENU);
        btn_sel = 1'b0;
        step("guard_rel");

        press(4'b0100, "restart");
        press(4'b1000, "pause2");
        check("paused", obs(0, 0), S_PAUSE);
        btn_pause = 1'b1; btn_sel = 1'b1;
        step("pause_sel");
        check("pause_sel_play", obs(0, 0), S_PLAY);
        check("resume_no_pulse", obs(0, 3), 0);
        btn_pause = 1'b0; btn_sel = 1'b0;
        step("pause_sel_rel");
        press(4'b1000, "pause3");
        press(4'b0100, "quit");
        check("quit_menu", obs(0, 0), S_MENU);
        check("quit_sel_kept", obs(0, 1), 1);
        check("quit_mode_kept", obs(0, 2), 1);

        press(4'b0100, "start3");
        press(4'b1000, "pause4");
        check("pause_before_rst", obs(0, 0), S_PAUSE);
        async_reset("areset");
        check("areset_state", obs(0, 0), S_MENU);
        check("areset_mode", obs(0, 2), 0);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) btn_up    = ~btn_up;
            if ($urandom_range(0, 3) == 0) btn_down  = ~btn_down;
            if ($urandom_range(0, 3) == 0) btn_sel   = ~btn_sel;
            if ($urandom_range(0, 4) == 0) btn_pause = ~btn_pause;
            game_over = ($urandom_range(0, 9) == 0);
            step("rand");
            if ($urandom_range(0, 299) == 0) async_reset("rand_areset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/menu_ctrl.md
# menu_ctrl

Parametrised top-level game-state controller for the VGA game, replacing the single-button MENU→PLAY selector. It edge-detects the player buttons, moves a wrap-around cursor over `NUM_ITEMS` menu entries, and sequences MENU / PLAY / PAUSE / OVER. It latches the chosen menu entry as the play mode and issues a one-cycle start pulse to the play logic. All outputs are registered and drive the renderer and play logic directly.

## Interface
- `NUM_ITEMS`, default 4: number of menu entries, must be ≥ 1.
- `IDX_W`, default `max(1, $clog2(NUM_ITEMS))`: cursor/mode width, derived and not overridden.
- `GUARD_CYC`, default 50_000_000: cycles on the OVER screen during which `btn_sel` is ignored. 0 means no guard.
- `clk` in 1: system clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `btn_up` in 1: cursor up, level, already synchronised and debounced.
- `btn_down` in 1: cursor down, level.
- `btn_sel` in 1: select / confirm / quit, level.
- `btn_pause` in 1: pause toggle, level.
- `game_over` in 1: from play logic, sampled only in PLAY.
- `state` out 2: current game state.
- `sel_idx` out IDX_W: menu cursor position.
- `mode` out IDX_W: entry latched at game start.
- `start_pulse` out 1: high for exactly one cycle on each MENU→PLAY transition.

## Operation
- **Edge detection.** Each button has a `prev` register; `evt = btn & ~prev`. `prev` resets to 1, so a button held through reset produces no event until it is released and pressed again.
- **Reset.** All outputs reset as follows: `state`=MENU, `sel_idx`=0, `mode`=0, `start_pulse`=0, guard counter=0.
- **MENU**
  - up event: `sel_idx` decrements, wrapping 0 → NUM_ITEMS−1.
  - down event: `sel_idx` increments, wrapping NUM_ITEMS−1 → 0.
  - up and down in the same cycle: `sel_idx` unchanged.
  - `NUM_ITEMS`=1: `sel_idx` stays 0.
  - sel event: go to PLAY, `mode` ← `sel_idx`, `start_pulse`=1. A sel event takes priority over a same-cycle up/down event, and the un-moved `sel_idx` is latched.
- **PLAY**
  - `game_over`=1: go to OVER and load the guard counter with `GUARD_CYC`. `game_over` wins over a same-cycle pause event.
  - Otherwise, pause event: go to PAUSE.
  - up/down/sel events are ignored.
- **PAUSE**
  - pause event: go to PLAY, with no `start_pulse`.
  - sel event: go to MENU. `sel_idx` is kept; `mode` is kept until the next start.
  - pause and sel in the same cycle: pause wins, go to PLAY.
  - `game_over` is ignored.
- **OVER**
  - Guard counter decrements to 0 and saturates there.
  - sel event while counter ≠ 0: ignored.
  - sel event while counter = 0: go to MENU.
- **Encoding.** State encoding is fixed: MENU=2'b00, PLAY=2'b01, PAUSE=2'b10, OVER=2'b11. No illegal states exist.
- **Mid-operation reset.** Asserting `rstn` in any state forces the reset values immediately, asynchronously.

## Timing
- A button high at rising edge k with `prev`=0 is an event at edge k. `state`, `sel_idx`, `mode` and `start_pulse` show the result after edge k, i.e. one cycle of latency from the input being sampled.
- `start_pulse` is high during the single cycle following the transition edge and low otherwise.
- `game_over` is level-sampled, not edge-detected. Its effect follows the same one-edge latency.
- Guard: the counter is loaded at the edge entering OVER. The first accepted sel is at or after edge `GUARD_CYC`+1 counted from entry.
- A held button produces exactly one event per press.

## Structure
- Shared package `game_pkg` holds:
  - state localparams MENU/PLAY/PAUSE/OVER, for reuse by the renderer and play logic;
  - the 2-bit state width.
- One natural sub-module: `btn_edge`, a one-bit rising-edge detector with `prev` reset to 1. It is instantiated four times.
- Guard counter width is `$clog2(GUARD_CYC+1)`, minimum 1 bit.

## Test plan
- **Reset with button held:** hold `btn_sel`=1 through reset release → `state` stays MENU; release then press → PLAY after one edge, with `start_pulse` high for exactly 1 cycle.
- **Cursor wrap:** `NUM_ITEMS`=4; 1 up press → `sel_idx`=3; 2 down presses → `sel_idx`=1; up+down in the same cycle → still 1. Then sel → `mode`=1.
- **Pause priority:** in PLAY, assert `game_over` and a pause press in the same cycle → OVER. Separately: pause press → PAUSE; pause+sel together → PLAY with `start_pulse`=0; in PAUSE, sel → MENU with `sel_idx` retained.
- **Guard window:** `GUARD_CYC`=10; enter OVER; sel press at cycle 5 → still OVER; sel press at cycle 12 → MENU.
- **Asynchronous reset:** assert `rstn`=0 mid-PAUSE between clock edges → `state`=MENU and `mode`=0 immediately, without waiting for a clock edge.
- **Degenerate config:** `NUM_ITEMS`=1 → up/down presses leave `sel_idx`=0; sel → PLAY with `mode`=0.
